// File: rtl/aes128_decrypt_iter.sv
// -----------------------------------------------------------------------------
// aes128_decrypt_iter
//
// Iterative AES-128 decryptor, one inverse round per clock. Ciphertext and key
// arrive over a valid/ready stream and the plaintext leaves over another one.
// A one-entry cache remembers the last key and its round-10 key, so repeated
// blocks under the same key skip the ten forward key-expansion steps.
//
// Byte order is FIPS-197: bits [127:120] are byte 0, bytes fill the state
// column by column (byte n sits at row n%4, column n/4).
//
// Parameters:
//   KEY_CACHE   1 enables the round-10 key cache, 0 forces expansion per block
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   in_valid    ciphertext/key valid
//   in_ready    block accepts input (IDLE only)
//   ciphertext  128-bit ciphertext block
//   key         128-bit cipher key (round-0 key)
//   out_valid   plaintext valid, held until accepted
//   out_ready   downstream accepts plaintext
//   plaintext   128-bit decrypted block
// -----------------------------------------------------------------------------
module aes128_decrypt_iter #(
    parameter int KEY_CACHE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plaintext
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        ROUND  = 2'd2,
        DONE   = 2'd3
    } fsmState_t;

    // ------------------------------------------------------------------
    // GF(2^8) arithmetic, reduction polynomial x^8+x^4+x^3+x+1
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gfInv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x7, x12, x14, x15, x30, x60, x120, x240;
        x2   = gfMul(a, a);
        x3   = gfMul(x2, a);
        x6   = gfMul(x3, x3);
        x7   = gfMul(x6, a);
        x12  = gfMul(x6, x6);
        x14  = gfMul(x7, x7);
        x15  = gfMul(x12, x3);
        x30  = gfMul(x15, x15);
        x60  = gfMul(x30, x30);
        x120 = gfMul(x60, x60);
        x240 = gfMul(x120, x120);
        return gfMul(x240, x14);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gfInv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    // Inverse affine first, then inversion.
    function automatic logic [7:0] invSbox(input logic [7:0] x);
        return gfInv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State transforms
    // ------------------------------------------------------------------
    // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = invSbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] invMixCol(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = w[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = invMixCol(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fsmState_t    fsmState_q,  fsmState_d;
    logic [127:0] block_q,     block_d;
    logic [127:0] keyReg_q,    keyReg_d;
    logic [127:0] origKey_q,   origKey_d;
    logic [3:0]   keyCnt_q,    keyCnt_d;
    logic [3:0]   rnd_q,       rnd_d;
    logic [127:0] cacheKey_q,  cacheKey_d;
    logic [127:0] cacheRk10_q, cacheRk10_d;
    logic         cacheVld_q,  cacheVld_d;

    // Shared key-schedule datapath. The four forward S-boxes see w3 while
    // expanding forward and w3^w2 (the recovered previous w3) while rolling
    // the schedule back, so one SubWord serves both directions.
    logic [31:0]  kw0, kw1, kw2, kw3;
    logic [31:0]  sbWordIn;
    logic [31:0]  subRot;
    logic [7:0]   rconByte;
    logic [127:0] fwdRk;
    logic [127:0] invRk;
    logic [127:0] invBase;
    logic [127:0] roundOut;
    logic         cacheHit;

    // Key schedule step (forward or inverse), round datapath and the whole
    // next-state decision for FSM and data registers live in one process.
    always_comb begin
        kw0 = keyReg_q[127:96];
        kw1 = keyReg_q[95:64];
        kw2 = keyReg_q[63:32];
        kw3 = keyReg_q[31:0];

        sbWordIn = (fsmState_q == ROUND) ? (kw3 ^ kw2) : kw3;
        subRot   = subWord({sbWordIn[23:0], sbWordIn[31:24]});
        rconByte = rcon((fsmState_q == ROUND) ? (4'd11 - rnd_q) : keyCnt_q);

        fwdRk[127:96] = kw0 ^ subRot ^ {rconByte, 24'h0};
        fwdRk[95:64]  = kw1 ^ fwdRk[127:96];
        fwdRk[63:32]  = kw2 ^ fwdRk[95:64];
        fwdRk[31:0]   = kw3 ^ fwdRk[63:32];

        invRk[127:96] = kw0 ^ subRot ^ {rconByte, 24'h0};
        invRk[95:64]  = kw1 ^ kw0;
        invRk[63:32]  = kw2 ^ kw1;
        invRk[31:0]   = kw3 ^ kw2;

        invBase  = invSubBytes(invShiftRows(block_q));
        roundOut = (rnd_q == 4'd10) ? (invBase ^ invRk)
                                    : invMixColumns(invBase ^ invRk);

        cacheHit = (KEY_CACHE != 0) && cacheVld_q && (key == cacheKey_q);

        fsmState_d  = fsmState_q;
        block_d     = block_q;
        keyReg_d    = keyReg_q;
        origKey_d   = origKey_q;
        keyCnt_d    = keyCnt_q;
        rnd_d       = rnd_q;
        cacheKey_d  = cacheKey_q;
        cacheRk10_d = cacheRk10_q;
        cacheVld_d  = cacheVld_q;

        in_ready  = (fsmState_q == IDLE) && !rst;
        out_valid = (fsmState_q == DONE);
        plaintext = (fsmState_q == DONE) ? block_q : 128'h0;

        case (fsmState_q)
            IDLE: begin
                if (in_valid) begin
                    origKey_d = key;
                    if (cacheHit) begin
                        block_d    = ciphertext ^ cacheRk10_q;
                        keyReg_d   = cacheRk10_q;
                        rnd_d      = 4'd1;
                        fsmState_d = ROUND;
                    end else begin
                        block_d    = ciphertext;
                        keyReg_d   = key;
                        keyCnt_d   = 4'd1;
                        fsmState_d = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                keyReg_d = fwdRk;
                if (keyCnt_q == 4'd10) begin
                    // fwdRk is rk10 on this step: whiten and fill the cache.
                    block_d    = block_q ^ fwdRk;
                    keyCnt_d   = 4'd0;
                    rnd_d      = 4'd1;
                    fsmState_d = ROUND;
                    if (KEY_CACHE != 0) begin
                        cacheKey_d  = origKey_q;
                        cacheRk10_d = fwdRk;
                        cacheVld_d  = 1'b1;
                    end
                end else begin
                    keyCnt_d = keyCnt_q + 4'd1;
                end
            end
            ROUND: begin
                block_d  = roundOut;
                keyReg_d = invRk;
                if (rnd_q == 4'd10) begin
                    rnd_d      = 4'd0;
                    fsmState_d = DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            DONE: begin
                if (out_ready) fsmState_d = IDLE;
            end
            default: fsmState_d = IDLE;
        endcase
    end

    // All state updates, including cache invalidation, happen on the
    // rising edge; reset aborts any block in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsmState_q  <= IDLE;
            block_q     <= '0;
            keyReg_q    <= '0;
            origKey_q   <= '0;
            keyCnt_q    <= '0;
            rnd_q       <= '0;
            cacheKey_q  <= '0;
            cacheRk10_q <= '0;
            cacheVld_q  <= 1'b0;
        end else begin
            fsmState_q  <= fsmState_d;
            block_q     <= block_d;
            keyReg_q    <= keyReg_d;
            origKey_q   <= origKey_d;
            keyCnt_q    <= keyCnt_d;
            rnd_q       <= rnd_d;
            cacheKey_q  <= cacheKey_d;
            cacheRk10_q <= cacheRk10_d;
            cacheVld_q  <= cacheVld_d;
        end
    end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// -----------------------------------------------------------------------------
// tb_aes128_decrypt_iter
//
// Directed bench for aes128_decrypt_iter: known-answer vectors (FIPS-197 and
// SP800-38A ECB) applied from a table with expected latency per cache state,
// plus hand-written sequences for reset, back-pressure and mid-round abort.
// -----------------------------------------------------------------------------
module tb_aes128_decrypt_iter;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ciphertext;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plaintext;

    int nCompared;
    int nMismatched;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs [8];

    aes128_decrypt_iter #(.KEY_CACHE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ciphertext (ciphertext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .plaintext  (plaintext)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, launches one block, scrambles the inputs
    // after the accept edge, then measures edges until out_valid.
    task automatic applyStimulus(input logic [127:0] k, input logic [127:0] ct,
                                 input logic [127:0] pt, input int lat,
                                 input string name);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({name, "_ready"}, 128'(in_ready), 128'(1));
        key        = k;
        ciphertext = ct;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        key        = {$urandom, $urandom, $urandom, $urandom};
        ciphertext = {$urandom, $urandom, $urandom, $urandom};
        checkOutput({name, "_busy"}, 128'(in_ready), 128'(0));
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput({name, "_lat"}, 128'(cyc), 128'(lat));
        checkOutput({name, "_pt"}, plaintext, pt);
    endtask

    initial begin
        int seen;
        logic [127:0] heldPt;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                    128'h3243f6a8885a308d313198a2e0370734, 20, "fipsB_cold"};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    128'h6bc1bee22e409f96e93d7e117393172a, 10, "ecb1_hit"};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hf5d3d58503b9699de785895a96fdbaaf,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 10, "ecb2_hit"};
        vecs[3] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h00112233445566778899aabbccddeeff, 20, "fipsC1_miss"};
        vecs[4] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h43b1cd7f598ece23881b00e3ed030688,
                    128'h30c81c46a35ce411e5fbc1191a0a52ef, 20, "ecb3_miss"};
        vecs[5] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h7b0c785e27e8ad3f8223207104725dd4,
                    128'hf69f2445df4f9b17ad2b417be66c3710, 10, "ecb4_hit"};
        vecs[6] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 20, "zero_miss"};
        vecs[7] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0, 10, "zero_hit"};

        nCompared   = 0;
        nMismatched = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        key         = '0;
        ciphertext  = '0;

        // Reset values, then in_ready right after release.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
        checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
        checkOutput("rst_plaintext", plaintext, 128'h0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_in_ready", 128'(in_ready), 128'(1));

        // Known-answer table; cache hits and misses follow key history.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].lat, vecs[i].name);
        end

        // With out_ready high, DONE leaves on the next edge and IDLE is back.
        @(posedge clk); #1;
        checkOutput("done_exit_valid", 128'(out_valid), 128'(0));
        checkOutput("done_exit_ready", 128'(in_ready), 128'(1));

        // Back-pressure: hold DONE for 7 cycles while poking in_valid.
        out_ready = 1'b0;
        applyStimulus(vecs[1].key, vecs[1].ct, vecs[1].pt, 20, "bp_block");
        heldPt = plaintext;
        for (int i = 0; i < 7; i++) begin
            in_valid   = 1'b1;
            key        = vecs[3].key;
            ciphertext = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            in_valid = 1'b0;
            checkOutput($sformatf("bp_valid_%0d", i), 128'(out_valid), 128'(1));
            checkOutput($sformatf("bp_pt_%0d", i), plaintext, vecs[1].pt);
            checkOutput($sformatf("bp_ready_%0d", i), 128'(in_ready), 128'(0));
        end
        checkOutput("bp_pt_stable", plaintext, heldPt);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", 128'(out_valid), 128'(0));
        // Ignored pulses must not have disturbed the cached key.
        applyStimulus(vecs[2].key, vecs[2].ct, vecs[2].pt, 10, "bp_after_hit");

        // Abort mid-ROUND after 5 rounds of a hit block: no output, cache gone.
        applyStimulus(vecs[6].key, vecs[6].ct, vecs[6].pt, 20, "abort_prime");
        @(posedge clk); #1;
        key        = vecs[6].key;
        ciphertext = vecs[6].ct;
        in_valid   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        checkOutput("abort_no_output", 128'(seen), 128'(0));
        applyStimulus(vecs[6].key, vecs[6].ct, vecs[6].pt, 20, "abort_then_miss");
        applyStimulus(vecs[6].key, vecs[6].ct, vecs[6].pt, 10, "abort_then_hit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/aes128_decrypt_iter.md
# aes128_decrypt_iter

Iterative AES-128 decryptor, one round per clock. It inverts the output of the pipelined `aes128_encrypt` core and returns plaintext over a valid/ready stream. It sits on the receive side of the extractor datapath. It keeps a one-entry round-10 key cache, so back-to-back blocks under the same key skip forward key expansion.

## Interface
Parameters:
- `KEY_CACHE`, default 1: enables the round-10 key cache. When 0, every block runs key expansion.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  `ciphertext`/`key` are valid.
- `in_ready`  out  1  block accepts input; high only in IDLE.
- `ciphertext`  in  128  FIPS-197 byte order; bits [127:120] are byte 0, column-major.
- `key`  in  128  cipher key (round-0 key), same byte order.
- `out_valid`  out  1  `plaintext` is valid; held until accepted.
- `out_ready`  in  1  downstream accepts `plaintext`.
- `plaintext`  out  128  decrypted block.

## Operation
- **States:** IDLE, KEYEXP, ROUND, DONE.
- **Accept:** a rising edge with `in_valid & in_ready`.
- **IDLE, accept with a cache hit** (`KEY_CACHE=1`, `cache_vld=1`, `key == cache_key`):
  - state ← `ciphertext ^ rk10`
  - `rnd` ← 1
  - go to ROUND.
- **IDLE, accept with a cache miss:**
  - state ← `ciphertext`
  - `kreg` ← `key`
  - `kcnt` ← 1
  - go to KEYEXP.
- **KEYEXP** (one forward expansion step per edge, Rcon 01,02,04,08,10,20,40,80,1b,36 indexed by `kcnt`):
  - `kreg` ← `next_rk(kreg, kcnt)`
  - on `kcnt == 10`: `kreg` already holds rk10, state ← `state ^ rk10`, `cache_key` ← `key` captured at accept, `cache_vld` ← 1, `rnd` ← 1, go to ROUND.
  - Otherwise `kcnt++`.
- **ROUND**, rounds r = 1..10 (`kreg` holds rk(10-r+1) on entry and is rolled back one step per round):
  - rk_prev = `inv_rk(kreg, Rcon[11-r])`
  - rows: w3' = w3^w2, w2' = w2^w1, w1' = w1^w0, w0' = w0 ^ SubWord(RotWord(w3')) ^ Rcon.
  - r < 10: state ← `InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_prev)`.
  - r = 10: state ← `InvSubBytes(InvShiftRows(state)) ^ rk0`, go to DONE.
  - `kreg` ← rk_prev.
- **Key register across blocks:**
  - On a cache hit, `kreg` ← `cache_rk10` at accept.
  - `cache_rk10` is written when KEYEXP completes.
  - The cache holds the key and rk10 only, never intermediate keys.
- **DONE:**
  - `out_valid` = 1 and `plaintext` = state.
  - On `out_ready`, go to IDLE.
  - `plaintext` and `out_valid` do not change while stalled.
- **S-box logic:** forward and inverse S-box are combinational, built from GF(2^8) inversion plus affine or inverse-affine (no ROM). 16 inverse S-boxes serve the state; 4 forward S-boxes serve the key.
- **Arithmetic:** `xtime` reduces by 0x1b. InvMixColumns uses coefficients 0e, 0b, 0d, 09.

## Timing
- **Reset values:**
  - outputs: `out_valid` = 0, `plaintext` = 0, `in_ready` = 0 while `rst` is high.
  - internal: state = IDLE, `cache_vld` = 0, counters = 0.
  - `in_ready` = 1 on the first cycle after `rst` deasserts.
- **Latency, accept edge T to first edge with `out_valid` high:**
  - cache hit: T+10.
  - cache miss: T+20 (10 KEYEXP edges plus 10 ROUND edges).
- **Throughput with `out_ready` tied high:**
  - DONE to IDLE takes 1 edge, and IDLE to accept takes 1 edge.
  - Hit-stream period is 12 cycles.
- **No overlap:** `in_ready` is low in KEYEXP, ROUND and DONE. Input changes there are ignored.
- **`rst` mid-operation:** aborts at that edge. No `out_valid` pulse, cache invalidated, input data discarded.
- **`KEY_CACHE=0`:** always takes the miss path; `cache_vld` stays 0.
- **`out_valid` / `out_ready` handshake:**
  - `out_ready` asserted before DONE has no effect.
  - `out_valid` falls on the edge after `out_ready` is sampled high in DONE.

## Test plan
- **FIPS-197 App. B, cold:** `key=2b7e151628aed2a6abf7158809cf4f3c`, `ct=3925841d02dc09fbdc118597196a0b32` → `plaintext=3243f6a8885a308d313198a2e0370734`, `out_valid` at T+20.
- **Same key, second block, hit:** `ct=69c4...` replaced by the `aes128_encrypt` output of random pt → plaintext matches, `out_valid` at T+10.
- **FIPS-197 C.1, key change:** `key=000102030405060708090a0b0c0d0e0f`, `ct=69c4e0d86a7b0430d8cdb78070b4c55a` → `00112233445566778899aabbccddeeff`, miss latency 20.
- **Back-pressure:** `out_ready=0` for 7 cycles in DONE → `plaintext` stable, `in_ready=0`, `in_valid` pulses ignored. Raise `out_ready` → `out_valid` drops the next edge.
- **Reset mid-ROUND** (after 5 rounds) → no output. The next block under the same key takes the miss path (latency 20) and is correct.
- **Loopback against `aes128_encrypt`:** 1000 random key/pt pairs with keys repeating in runs of 1–4 → every decrypted block equals its pt, and latency is 10 or 20 per cache state.
